// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_PORTS finished results per cycle
// (optional fixed-priority requester, then round-robin) and registers them onto the CDB.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 5,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned TAG_W     = 3,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_EN   = 1,
  parameter int unsigned PRIO_IDX  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  output logic [NUM_PORTS-1:0]          cdb_valid,
  output logic [NUM_PORTS*TAG_W-1:0]    cdb_tag,
  output logic [NUM_PORTS*DATA_W-1:0]   cdb_data,
  output logic                          err_dup_tag,
  output logic [15:0]                   conflict_cnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]            rr_ptr;
  logic [PTR_W-1:0]            rr_next;
  logic [PTR_W-1:0]            idx;
  logic [TAG_W-1:0]            tag_arr  [NUM_REQ];
  logic [DATA_W-1:0]           data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_PORTS-1:0]        sel_valid;
  logic [NUM_PORTS*TAG_W-1:0]  sel_tag;
  logic [NUM_PORTS*DATA_W-1:0] sel_data;
  logic                        dup_tag;
  logic                        conflict;
  int                          taken;
  int                          scan_idx;

  // Unpack flat request buses into per-requester arrays
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      tag_arr[i]  = req_tag[i*TAG_W +: TAG_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Priority requester first, then round-robin scan from rr_ptr; k-th pick goes to port k
  always_comb begin
    grant     = '0;
    sel_valid = '0;
    sel_tag   = '0;
    sel_data  = '0;
    rr_next   = rr_ptr;
    taken     = 0;
    scan_idx  = 0;
    idx       = '0;
    if (!flush) begin
      if (PRIO_EN != 0 && req_valid[PRIO_IDX]) begin
        grant[PRIO_IDX]       = 1'b1;
        sel_valid[0]          = 1'b1;
        sel_tag[TAG_W-1:0]    = tag_arr[PRIO_IDX];
        sel_data[DATA_W-1:0]  = data_arr[PRIO_IDX];
        taken                 = 1;
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        scan_idx = int'(rr_ptr) + j;
        if (scan_idx >= int'(NUM_REQ)) scan_idx = scan_idx - int'(NUM_REQ);
        idx = PTR_W'(scan_idx);
        if (taken < int'(NUM_PORTS) && req_valid[idx] &&
            !(PRIO_EN != 0 && idx == PTR_W'(PRIO_IDX))) begin
          grant[idx] = 1'b1;
          for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (taken == p) begin
              sel_valid[p]                  = 1'b1;
              sel_tag[p*TAG_W +: TAG_W]     = tag_arr[idx];
              sel_data[p*DATA_W +: DATA_W]  = data_arr[idx];
            end
          end
          rr_next = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
          taken   = taken + 1;
        end
      end
    end
  end

  // Diagnostic: any two ports picked this cycle carrying the same ROB tag
  always_comb begin
    dup_tag = 1'b0;
    for (int a = 0; a < int'(NUM_PORTS); a++) begin
      for (int b = a + 1; b < int'(NUM_PORTS); b++) begin
        if (sel_valid[a] && sel_valid[b] &&
            sel_tag[a*TAG_W +: TAG_W] == sel_tag[b*TAG_W +: TAG_W]) begin
          dup_tag = 1'b1;
        end
      end
    end
  end

  assign conflict  = !flush && ($countones(req_valid) > int'(NUM_PORTS));
  assign req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid    <= '0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
      err_dup_tag  <= 1'b0;
      conflict_cnt <= '0;
      rr_ptr       <= '0;
    end else begin
      cdb_valid <= sel_valid;
      cdb_tag   <= sel_tag;
      cdb_data  <= sel_data;
      rr_ptr    <= rr_next;
      if (dup_tag) err_dup_tag <= 1'b1;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for rotation/priority/flush/boundaries,
// plus hand sequences for duplicate tags, counter saturation and asynchronous reset.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst_n;
  logic [4:0]   req_valid;
  logic [14:0]  req_tag;
  logic [159:0] req_data;
  logic [4:0]   req_ready;
  logic         flush;
  logic [1:0]   cdb_valid;
  logic [5:0]   cdb_tag;
  logic [63:0]  cdb_data;
  logic         err_dup_tag;
  logic [15:0]  conflict_cnt;

  logic [2:0]   tag_tb [5];
  int           checks;
  int           errors;

  typedef struct packed {
    logic [4:0]  valid;
    logic        flush;
    logic [4:0]  ready;
    logic [1:0]  cv;
    logic [2:0]  t0;
    logic [2:0]  t1;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [19];

  cdb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .flush        (flush),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .err_dup_tag  (err_dup_tag),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result data is derived from the tag so expected data follows from expected tag
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      req_tag[i*3 +: 3]   = tag_tb[i];
      req_data[i*32 +: 32] = 32'h1000_0000 + 32'(tag_tb[i]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic v, input logic [2:0] t);
    return v ? 32'h1000_0000 + 32'(t) : 32'h0;
  endfunction

  task automatic check_cdb(input string pfx, input logic [1:0] cv,
                           input logic [2:0] t0, input logic [2:0] t1);
    chk({pfx, ".cdb_valid"}, 32'(cdb_valid), 32'(cv));
    chk({pfx, ".tag0"}, 32'(cdb_tag[2:0]), 32'(t0));
    chk({pfx, ".tag1"}, 32'(cdb_tag[5:3]), 32'(t1));
    chk({pfx, ".data0"}, cdb_data[31:0], exp_data(cv[0], t0));
    chk({pfx, ".data1"}, cdb_data[63:32], exp_data(cv[1], t1));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    for (int i = 0; i < 5; i++) tag_tb[i] = 3'(i);

    //            valid    fl    ready    cv     t0    t1    cnt
    vecs[0]  = '{5'b01111, 1'b0, 5'b00011, 2'b11, 3'd0, 3'd1, 16'd1};
    vecs[1]  = '{5'b01111, 1'b0, 5'b01100, 2'b11, 3'd2, 3'd3, 16'd2};
    vecs[2]  = '{5'b01111, 1'b0, 5'b00011, 2'b11, 3'd0, 3'd1, 16'd3};
    vecs[3]  = '{5'b01111, 1'b0, 5'b01100, 2'b11, 3'd2, 3'd3, 16'd4};
    vecs[4]  = '{5'b11111, 1'b0, 5'b10001, 2'b11, 3'd4, 3'd0, 16'd5};
    vecs[5]  = '{5'b11111, 1'b0, 5'b10010, 2'b11, 3'd4, 3'd1, 16'd6};
    vecs[6]  = '{5'b11111, 1'b0, 5'b10100, 2'b11, 3'd4, 3'd2, 16'd7};
    vecs[7]  = '{5'b11111, 1'b0, 5'b11000, 2'b11, 3'd4, 3'd3, 16'd8};
    vecs[8]  = '{5'b00011, 1'b0, 5'b00011, 2'b11, 3'd0, 3'd1, 16'd8};
    vecs[9]  = '{5'b00011, 1'b1, 5'b00000, 2'b00, 3'd0, 3'd0, 16'd8};
    vecs[10] = '{5'b00011, 1'b1, 5'b00000, 2'b00, 3'd0, 3'd0, 16'd8};
    vecs[11] = '{5'b00111, 1'b0, 5'b00101, 2'b11, 3'd2, 3'd0, 16'd9};
    vecs[12] = '{5'b00011, 1'b0, 5'b00011, 2'b11, 3'd1, 3'd0, 16'd9};
    vecs[13] = '{5'b00100, 1'b0, 5'b00100, 2'b01, 3'd2, 3'd0, 16'd9};
    vecs[14] = '{5'b10000, 1'b0, 5'b10000, 2'b01, 3'd4, 3'd0, 16'd9};
    vecs[15] = '{5'b00001, 1'b0, 5'b00001, 2'b01, 3'd0, 3'd0, 16'd9};
    vecs[16] = '{5'b11000, 1'b0, 5'b11000, 2'b11, 3'd4, 3'd3, 16'd9};
    vecs[17] = '{5'b01001, 1'b0, 5'b01001, 2'b11, 3'd0, 3'd3, 16'd9};
    vecs[18] = '{5'b00000, 1'b0, 5'b00000, 2'b00, 3'd0, 3'd0, 16'd9};

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_cdb("reset", 2'b00, 3'd0, 3'd0);
    chk("reset.err_dup_tag", 32'(err_dup_tag), 32'd0);
    chk("reset.conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("reset.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: rotation, priority, flush hold, wrap and single-requester cases
    for (int k = 0; k < 19; k++) begin
      req_valid = vecs[k].valid;
      flush     = vecs[k].flush;
      #1;
      chk($sformatf("v%0d.req_ready", k), 32'(req_ready), 32'(vecs[k].ready));
      @(posedge clk);
      #1;
      check_cdb($sformatf("v%0d", k), vecs[k].cv, vecs[k].t0, vecs[k].t1);
      chk($sformatf("v%0d.conflict_cnt", k), 32'(conflict_cnt), 32'(vecs[k].cnt));
      chk($sformatf("v%0d.err_dup_tag", k), 32'(err_dup_tag), 32'd0);
    end

    // Duplicate tag: both still broadcast, error flag sticky
    tag_tb[1] = 3'd5;
    tag_tb[2] = 3'd5;
    req_valid = 5'b00110;
    #1;
    chk("dup.req_ready", 32'(req_ready), 32'b00110);
    @(posedge clk);
    #1;
    check_cdb("dup", 2'b11, 3'd5, 3'd5);
    chk("dup.err_dup_tag", 32'(err_dup_tag), 32'd1);
    req_valid = '0;
    tag_tb[1] = 3'd1;
    tag_tb[2] = 3'd2;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("dup_hold%0d.err_dup_tag", k), 32'(err_dup_tag), 32'd1);
      chk($sformatf("dup_hold%0d.cdb_valid", k), 32'(cdb_valid), 32'd0);
    end
    chk("dup.conflict_cnt", 32'(conflict_cnt), 32'd9);

    // Saturation: three valid requests every cycle until the counter pins
    req_valid = 5'b00111;
    repeat (65525) @(posedge clk);
    #1;
    chk("sat.pre", 32'(conflict_cnt), 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.conflict_cnt", k), 32'(conflict_cnt), 32'h0000_FFFF);
    end

    // Asynchronous reset mid-cycle drops a live broadcast at once
    req_valid = 5'b00001;
    #1;
    chk("areset.req_ready", 32'(req_ready), 32'b00001);
    @(posedge clk);
    #1;
    chk("areset.pre_valid", 32'(cdb_valid), 32'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check_cdb("areset", 2'b00, 3'd0, 3'd0);
    chk("areset.conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("areset.err_dup_tag", 32'(err_dup_tag), 32'd0);
    req_valid = '0;
    #1;
    chk("areset.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
